// File: rtl/uart_frame_tx.sv
// UART frame transmitter: header byte, then N sign-extended samples sent LSB byte first.
// Build option: define UART_CHECKSUM_EN to append an XOR checksum byte of all data bytes.
module uart_frame_tx #(
  parameter int         CLK_FREQ  = 50_000_000,
  parameter int         BAUD      = 115200,
  parameter int         BIT_WIDTH = 24,
  parameter int         N         = 16,
  parameter logic [7:0] HEADER    = 8'hA5,
  localparam int        IDX_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  output logic                 sample_rd,
  output logic [IDX_W-1:0]     sample_idx,
  input  logic [BIT_WIDTH-1:0] sample_in,
  output logic                 busy,
  output logic                 done,
  output logic                 tx_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BYTES        = (BIT_WIDTH + 7) / 8;
  localparam int DW           = BYTES * 8;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W       = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE, SEND_HDR, FETCH, LATCH, SEND_DATA, END
`ifdef UART_CHECKSUM_EN
    , SEND_CSUM
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q;
  logic [3:0]        bit_q;
  logic [BYTE_W-1:0] byte_q;
  logic [IDX_W-1:0]  idx_q;
  logic [9:0]        shift_q;
  logic [DW-1:0]     data_q;
  logic [DW-1:0]     sext;
  logic              bit_end, byte_end, last_byte, last_idx;

  assign sext      = DW'($signed(sample_in));
  assign bit_end   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign byte_end  = bit_end && (bit_q == 4'd9);
  assign last_byte = (byte_q == BYTE_W'(BYTES - 1));
  assign last_idx  = (idx_q == IDX_W'(N - 1));

  // The shift register holds {stop, data, start}; it fills with ones as it
  // shifts, so the line rests at the stop level between bytes and in IDLE.
  assign tx_o       = shift_q[0];
  assign sample_rd  = (state_q == FETCH);
  assign sample_idx = idx_q;
  assign busy       = (state_q != IDLE) && (state_q != END);
  assign done       = (state_q == END);

`ifdef UART_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      csum_q <= '0;
    end else if (state_q == IDLE && start) begin
      csum_q <= '0;
    end else if (state_q == LATCH) begin
      csum_q <= csum_q ^ sext[7:0];
    end else if (state_q == SEND_DATA && byte_end && !last_byte) begin
      csum_q <= csum_q ^ data_q[7:0];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = SEND_HDR;
      SEND_HDR:  if (byte_end) state_d = FETCH;
      FETCH:     state_d = LATCH;
      LATCH:     state_d = SEND_DATA;
      SEND_DATA: begin
        if (byte_end && last_byte) begin
          if (!last_idx) state_d = FETCH;
`ifdef UART_CHECKSUM_EN
          else state_d = SEND_CSUM;
`else
          else state_d = END;
`endif
        end
      end
`ifdef UART_CHECKSUM_EN
      SEND_CSUM: if (byte_end) state_d = END;
`endif
      END:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      idx_q   <= '0;
      shift_q <= '1;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          byte_q <= '0;
          if (start) shift_q <= {1'b1, HEADER, 1'b0};
        end
        FETCH: ;
        LATCH: begin
          shift_q <= {1'b1, sext[7:0], 1'b0};
          data_q  <= sext >> 8;
        end
        END: idx_q <= '0;
        default: begin
          // Serialising states: header, sample bytes and the optional checksum.
          if (!bit_end) begin
            baud_q <= baud_q + 1'b1;
          end else begin
            baud_q <= '0;
            if (bit_q != 4'd9) begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= {1'b1, shift_q[9:1]};
            end else begin
              bit_q <= '0;
              if (state_q == SEND_DATA && !last_byte) begin
                byte_q  <= byte_q + 1'b1;
                shift_q <= {1'b1, data_q[7:0], 1'b0};
                data_q  <= data_q >> 8;
              end else begin
                byte_q <= '0;
                if (state_q == SEND_DATA && state_d == FETCH) idx_q <= idx_q + 1'b1;
`ifdef UART_CHECKSUM_EN
                if (state_d == SEND_CSUM) shift_q <= {1'b1, csum_q, 1'b0};
`endif
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: a 24-bit/N=2 instance and a 12-bit/N=1 instance, each
// driven in turn; the serial line is logged per cycle and decoded against a byte model.
module tb_uart_frame_tx;
  localparam int CPB = 4;
`ifdef UART_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go = 1'b0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  // Valid/ready does not apply here: start is a level sampled in IDLE, and the
  // sample source answers a one-cycle sample_rd with data on the next cycle.
  logic        start_a, rd_a, busy_a, done_a, tx_a;
  logic [0:0]  idx_a;
  logic [23:0] sin_a;
  logic [23:0] mem_a [2];
  logic        start_b, rd_b, busy_b, done_b, tx_b;
  logic [0:0]  idx_b;
  logic [11:0] sin_b;
  logic [11:0] mem_b [1];

  assign start_a = go & ~sel;
  assign start_b = go & sel;

  uart_frame_tx #(.CLK_FREQ(400), .BAUD(100), .BIT_WIDTH(24), .N(2)) dut_a (
    .CLK(clk), .RST_N(rst_n), .start(start_a), .sample_rd(rd_a), .sample_idx(idx_a),
    .sample_in(sin_a), .busy(busy_a), .done(done_a), .tx_o(tx_a));

  uart_frame_tx #(.CLK_FREQ(400), .BAUD(100), .BIT_WIDTH(12), .N(1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .start(start_b), .sample_rd(rd_b), .sample_idx(idx_b),
    .sample_in(sin_b), .busy(busy_b), .done(done_b), .tx_o(tx_b));

  // Read-latency-1 sources; data is garbage in every cycle but the one after a read.
  always @(posedge clk) sin_a <= rd_a ? mem_a[idx_a] : 24'($urandom);
  always @(posedge clk) sin_b <= rd_b ? mem_b[0] : 12'($urandom);

  int          total = 0;
  int          passed = 0;
  bit          txl [1024];
  bit          dnl [1024];
  bit          bsl [1024];
  bit          plan [1024];
  logic [31:0] rd_q [$];
  logic [7:0]  exp_q [$];
  logic [31:0] smp [$];
  int          exp_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: header, sign-extended sample bytes LSB first, optional XOR byte.
  task automatic model(input int w);
    logic [31:0] v;
    logic [7:0]  b, cs;
    int          nb;
    nb = (w + 7) / 8;
    cs = 8'h00;
    exp_q = {};
    exp_q.push_back(8'hA5);
    foreach (smp[i]) begin
      v = smp[i];
      if (w < 32 && v[w-1]) v = v | ~((32'd1 << w) - 32'd1);
      for (int k = 0; k < nb; k++) begin
        b = 8'(v >> (8 * k));
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    if (CSUM) exp_q.push_back(cs);
    exp_len = (1 + smp.size() * nb) * 10 * CPB + 2 * smp.size() + 1 + (CSUM ? 10 * CPB : 0);
  endtask

  task automatic clear_plan();
    foreach (plan[i]) plan[i] = 1'b0;
  endtask

  task automatic load_mems();
    foreach (smp[i]) begin
      if (i < 2) mem_a[i] = smp[i][23:0];
      if (i < 1) mem_b[i] = smp[i][11:0];
    end
  endtask

  // Log index i is the negedge inside the i-th cycle after the start-accept edge.
  task automatic capture(input int len);
    rd_q = {};
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      txl[i] = sel ? tx_b : tx_a;
      dnl[i] = sel ? done_b : done_a;
      bsl[i] = sel ? busy_b : busy_a;
      if (sel ? rd_b : rd_a) rd_q.push_back(sel ? 32'(idx_b) : 32'(idx_a));
      go = plan[i];
    end
  endtask

  task automatic check_frame(input int off);
    int         dn, p, cnt, bad, run;
    logic [8:0] got;
    chk("start_bit_fall", 32'(txl[off]), 32'd0);
    chk("busy_after_accept", 32'(bsl[off]), 32'd1);
    dn = off;
    while (dn < off + exp_len + 10 && !dnl[dn]) dn++;
    chk("done_latency", 32'(dn - off + 1), 32'(exp_len));
    cnt = 0;
    for (int i = off; i < off + exp_len + 10; i++) cnt += int'(dnl[i]);
    chk("done_pulses", 32'(cnt), 32'd1);
    chk("busy_in_done", 32'(bsl[dn]), 32'd0);
    p = off;
    foreach (exp_q[j]) begin
      while (p < dn && txl[p]) p++;
      if (p >= dn) begin
        chk("bytes_decoded", 32'(j), 32'(exp_q.size()));
        break;
      end
      for (int k = 0; k < 8; k++) got[k] = txl[p + 4 * k + 6];
      got[8] = txl[p + 38];
      chk($sformatf("byte%0d", j), 32'(got), {23'd0, 1'b1, exp_q[j]});
      p += 40;
    end
    while (p < dn && txl[p]) p++;
    chk("no_extra_bytes", 32'(p), 32'(dn));
    bad = 0;
    run = 0;
    for (int i = off; i <= dn; i++) begin
      if (!txl[i]) run++;
      else begin
        if (run % CPB != 0) bad++;
        run = 0;
      end
    end
    chk("low_runs_multiple_of_cpb", 32'(bad), 32'd0);
  endtask

  task automatic chk_rd(input int n, input int reps);
    chk("rd_count", 32'(rd_q.size()), 32'(n * reps));
    foreach (rd_q[i]) chk($sformatf("rd_idx%0d", i), rd_q[i], 32'(i % n));
  endtask

  task automatic run_frame(input bit s, input int w, input int n);
    sel = s;
    model(w);
    load_mems();
    clear_plan();
    @(negedge clk);
    go = 1'b1;
    capture(exp_len + 20);
    check_frame(0);
    chk_rd(n, 1);
  endtask

  initial begin
    int  cnt, i;
    bit  found;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_a", 32'(tx_a), 32'd1);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_rd_a", 32'(rd_a), 32'd0);
    chk("rst_idx_a", 32'(idx_a), 32'd0);
    chk("rst_tx_b", 32'(tx_b), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame, with start pulses while busy and during the done cycle
    smp = {32'h123456, 32'hFEDCBA};
    sel = 1'b0;
    model(24);
    load_mems();
    clear_plan();
    plan[100] = 1'b1;
    plan[exp_len - 1] = 1'b1;
    @(negedge clk);
    go = 1'b1;
    capture(exp_len + 40);
    check_frame(0);
    chk_rd(2, 1);
    cnt = 0;
    for (int k = exp_len; k < exp_len + 40; k++) cnt += int'(!txl[k]) + int'(bsl[k]);
    chk("no_restart_after_done", 32'(cnt), 32'd0);

    // Back-to-back: start in the cycle after done opens a second frame
    smp = {32'($urandom_range(0, 32'hFFFFFF)), 32'($urandom_range(0, 32'hFFFFFF))};
    model(24);
    load_mems();
    clear_plan();
    plan[exp_len] = 1'b1;
    @(negedge clk);
    go = 1'b1;
    capture(2 * exp_len + 20);
    check_frame(0);
    check_frame(exp_len + 1);
    chk_rd(2, 2);

    // Sign extension on the 12-bit instance, directed then random
    smp = {32'h800};
    run_frame(1'b1, 12, 1);
    smp = {32'h7FF};
    run_frame(1'b1, 12, 1);
    for (int r = 0; r < 3; r++) begin
      smp = {32'($urandom_range(0, 32'hFFF))};
      run_frame(1'b1, 12, 1);
    end

    // Random 24-bit frames
    for (int r = 0; r < 3; r++) begin
      smp = {32'($urandom), 32'($urandom)};
      run_frame(1'b0, 24, 2);
    end

    // Asynchronous reset during a low data bit
    sel = 1'b0;
    smp = {32'h00FF00, 32'h0F0F0F};
    load_mems();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    i = 0;
    found = 1'b0;
    while (i < 200 && !found) begin
      @(negedge clk);
      i++;
      if (i > 60 && tx_a == 1'b0) found = 1'b1;
    end
    chk("reset_window_found", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx_a), 32'd1);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      cnt += int'(done_a) + int'(!tx_a);
    end
    chk("midrst_quiet", 32'(cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    smp = {32'h123456, 32'hFEDCBA};
    run_frame(1'b0, 24, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no end of run, expected finish");
    $fatal(1, "timeout");
  end

endmodule
